sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single-port board SRAM (21-bit word address, 32-bit data) between two requesters:
//   - the PCI host path (pci_*)
//   - the user FPGA compute engine (usr_*)
//  Each requester sees a req/gnt/rvalid interface; the arbiter serialises accesses, tracks the
//  memory read latency, and routes read data back to the originator. Sits between the PCI bridge,
//  the user engine and the SRAM controller pins.
// PARAMETERS
//  ADDR_W    21            word address width
//  DATA_W    32            data width
//  RD_LAT    1             SRAM read latency in cycles, mem_en -> mem_rdata valid (1..7)
//  MEM_DEPTH 21'h1F_FFFF   highest legal address; above it = out-of-range
//  ERR_DATA  32'hDEAD_BEEF data returned for out-of-range reads
// PORTS
//  clk        in  1       system clock, all logic rising-edge
//  rst_n      in  1       asynchronous active-low reset
//  pci_req    in  1       PCI access request; held with pci_we/addr/wdata until pci_gnt
//  pci_we     in  1       1 = write, 0 = read
//  pci_addr   in  ADDR_W  PCI word address
//  pci_wdata  in  DATA_W  PCI write data
//  pci_gnt    out 1       1-cycle pulse: PCI access issued to SRAM this cycle
//  pci_rvalid out 1       1-cycle pulse: pci_rdata valid
//  pci_rdata  out DATA_W  PCI read data, held until next pci_rvalid
//  usr_req / usr_we / usr_addr / usr_wdata / usr_gnt / usr_rvalid / usr_rdata
//             same as pci_* for the user engine
//  mem_en     out 1       SRAM access strobe
//  mem_we     out 1       SRAM write enable, qualified by mem_en
//  mem_addr   out ADDR_W  SRAM address
//  mem_wdata  out DATA_W  SRAM write data
//  mem_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after mem_en with mem_we=0
//  addr_err   out 1       1-cycle pulse coincident with gnt for an out-of-range access
//  busy       out 1       high in every state except IDLE
// BEHAVIOUR
//  - Reset values:
//    - all outputs 0, including rdata registers
//    - state = IDLE; last_grant = USR, so PCI wins the first tie
//  - FSM IDLE -> ISSUE -> (RWAIT) -> IDLE:
//    - IDLE: if any req, pick a winner and latch its we/addr/wdata; go to ISSUE.
//    - ISSUE (1 cycle): drive mem_en=1, mem_we/addr/wdata from the latch; winner's gnt=1.
//      - Write, or out-of-range access: go to IDLE.
//      - In-range read: load lat_cnt=RD_LAT, go to RWAIT.
//    - RWAIT: decrement lat_cnt each cycle. In the cycle lat_cnt==1:
//      - capture mem_rdata into the winner's rdata register;
//      - pulse rvalid on the next cycle;
//      - go to IDLE.
//  - Latency:
//    - write: req seen -> gnt in 1 cycle.
//    - read: gnt -> rvalid in RD_LAT+1 cycles.
//    - Next arbitration starts the cycle after returning to IDLE.
//  - Arbitration is round-robin on last_grant. If only one requester is active, it wins.
//    Each requester waits at most one foreign transaction.
//  - Requester must deassert or change req in the cycle after gnt. A req still high after gnt
//    is a new request.
//  - Out-of-range (addr > MEM_DEPTH):
//    - mem_en stays 0 in ISSUE; gnt and addr_err still pulse.
//    - Write: dropped.
//    - Read: rdata=ERR_DATA with rvalid the cycle after ISSUE.
//  - Request inputs are sampled only in IDLE. Changes during ISSUE/RWAIT are ignored.
//  - Async reset mid-transaction: immediate return to IDLE, no gnt/rvalid for the in-flight access.
//  - Exactly one of pci_gnt/usr_gnt may be high in any cycle; likewise for rvalid.
// STRUCTURE
//  - Package sram_arb_pkg:
//    - typedef enum {IDLE, ISSUE, RWAIT} arb_state_t
//    - typedef enum logic {REQ_PCI, REQ_USR} req_id_t
//    - ERR_DATA default
//    - access_t struct {we, addr, wdata}
//  - Sub-module rr_arb2: 2-way round-robin picker. Inputs req[1:0] and last; output win.
//    Purely combinational; last_grant register lives in the parent.
//  - Parent holds: FSM, request latch, lat_cnt (3 bits), rdata registers.
// TESTING
//  1. PCI write 0x0000_1234 @ 21'h10, then PCI read @ 21'h10, RD_LAT=1
//     -> pci_gnt 1 cycle after req; pci_rvalid 2 cycles after read gnt; pci_rdata 0x0000_1234.
//  2. pci_req and usr_req both high from reset
//     -> PCI granted first, USR next, then alternation PCI/USR over 8 back-to-back reads;
//        no double gnt.
//  3. usr_req alone, read @ 21'h7FFFE, RD_LAT=3 with model returning 0x0001_0000
//     -> usr_rvalid 4 cycles after usr_gnt; usr_rdata 0x0001_0000; pci_rvalid stays 0.
//  4. PCI read @ 21'h1F_FFFF with MEM_DEPTH=21'h0F_FFFF
//     -> mem_en stays 0; addr_err and pci_gnt pulse together; pci_rdata 0xDEAD_BEEF next cycle.
//  5. rst_n low during RWAIT of a USR read
//     -> outputs 0 at once, no usr_rvalid; after release a PCI read completes normally.
//  6. USR changes usr_addr during RWAIT -> in-flight read uses the latched address;
//     new address is served only after re-arbitration.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-requester SRAM port arbiter.
package sram_arb_pkg;

  // Widths of the board SRAM; the latched access record is sized by these.
  localparam int ARB_ADDR_W = 21;
  localparam int ARB_DATA_W = 32;

  // Highest legal word address and the data returned for reads beyond it.
  localparam logic [ARB_ADDR_W-1:0] MEM_DEPTH_DEF = 21'h1F_FFFF;
  localparam logic [ARB_DATA_W-1:0] ERR_DATA_DEF  = 32'hDEAD_BEEF;

  // Arbiter sequencing: wait for a request, drive the SRAM, wait for read data.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2
  } arb_state_t;

  // Requester identity; the encoding doubles as the bit index into req[1:0].
  typedef enum logic {
    REQ_PCI = 1'b0,
    REQ_USR = 1'b1
  } req_id_t;

  // One captured access, frozen while the transaction is in flight.
  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } access_t;

  // The requester that did not win last time.
  function automatic req_id_t other_id(input req_id_t id);
    return (id == REQ_PCI) ? REQ_USR : REQ_PCI;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Purely combinational; the caller owns the
// last-grant history and only consults win when at least one req is high.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output req_id_t    win
);

  // A lone requester always wins; on a tie the one not served last time wins.
  always_comb begin
    win = other_id(last);
    case (req)
      2'b01:   win = REQ_PCI;
      2'b10:   win = REQ_USR;
      2'b11:   win = other_id(last);
      default: win = other_id(last);
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the PCI host path and the user compute
// engine. Each access goes IDLE -> ISSUE -> (RWAIT) -> IDLE; read data is
// steered back to whichever requester owned the transaction.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int                 ADDR_W    = ARB_ADDR_W,
  parameter int                 DATA_W    = ARB_DATA_W,
  parameter int                 RD_LAT    = 1,
  parameter logic [ADDR_W-1:0]  MEM_DEPTH = ADDR_W'(MEM_DEPTH_DEF),
  parameter logic [DATA_W-1:0]  ERR_DATA  = DATA_W'(ERR_DATA_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  // PCI host requester
  input  logic              pci_req,
  input  logic              pci_we,
  input  logic [ADDR_W-1:0] pci_addr,
  input  logic [DATA_W-1:0] pci_wdata,
  output logic              pci_gnt,
  output logic              pci_rvalid,
  output logic [DATA_W-1:0] pci_rdata,
  // User engine requester
  input  logic              usr_req,
  input  logic              usr_we,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_wdata,
  output logic              usr_gnt,
  output logic              usr_rvalid,
  output logic [DATA_W-1:0] usr_rdata,
  // SRAM controller side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // Status
  output logic              addr_err,
  output logic              busy
);

  arb_state_t        state_reg, state_next;
  access_t           lat_reg;
  access_t           req_sel;
  req_id_t           owner_reg;
  req_id_t           last_grant_reg;
  req_id_t           win;
  logic [2:0]        lat_cnt_reg;
  logic [DATA_W-1:0] rdata_reg [2];
  logic [1:0]        rvalid_reg;

  logic              any_req;
  logic              issue;
  logic              oor;
  logic              rd_done;
  logic              err_rd;
  logic              ret_valid;
  logic [DATA_W-1:0] ret_data;

  assign any_req = pci_req | usr_req;
  assign issue   = (state_reg == ISSUE);
  // Range check uses the latched address so it is stable for the whole ISSUE cycle.
  assign oor     = (lat_reg.addr > MEM_DEPTH);

  rr_arb2 u_rr (
    .req  ({usr_req, pci_req}),
    .last (last_grant_reg),
    .win  (win)
  );

  // Mux the winning requester's command into the access record.
  always_comb begin
    req_sel.we    = pci_we;
    req_sel.addr  = pci_addr;
    req_sel.wdata = pci_wdata;
    if (win == REQ_USR) begin
      req_sel.we    = usr_we;
      req_sel.addr  = usr_addr;
      req_sel.wdata = usr_wdata;
    end
  end

  // FSM state register; an async reset drops any in-flight access on the floor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and SRAM/handshake outputs, all decoded from registered state.
  always_comb begin
    state_next = state_reg;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    pci_gnt    = 1'b0;
    usr_gnt    = 1'b0;
    addr_err   = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // Out-of-range accesses still grant, but never reach the SRAM pins.
        mem_en    = ~oor;
        mem_we    = ~oor & lat_reg.we;
        mem_addr  = oor ? '0 : lat_reg.addr;
        mem_wdata = oor ? '0 : lat_reg.wdata;
        pci_gnt   = (owner_reg == REQ_PCI);
        usr_gnt   = (owner_reg == REQ_USR);
        addr_err  = oor;
        state_next = (lat_reg.we || oor) ? IDLE : RWAIT;
      end
      RWAIT: begin
        // A zero count cannot occur in normal operation; leave rather than stall.
        if (lat_cnt_reg <= 3'd1) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the winner's command and advance round-robin history on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_reg        <= '0;
      owner_reg      <= REQ_PCI;
      last_grant_reg <= REQ_USR;
    end else if (state_reg == IDLE && any_req) begin
      lat_reg        <= req_sel;
      owner_reg      <= win;
      last_grant_reg <= win;
    end
  end

  // Read-latency counter: loaded as the read is issued, counted down while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_reg <= 3'd0;
    end else if (issue) begin
      lat_cnt_reg <= 3'(RD_LAT);
    end else if (state_reg == RWAIT) begin
      lat_cnt_reg <= lat_cnt_reg - 3'd1;
    end
  end

  // A read completes either from the SRAM after the latency, or at once with
  // the error pattern when its address was out of range.
  assign rd_done   = (state_reg == RWAIT) && (lat_cnt_reg <= 3'd1);
  assign err_rd    = issue && oor && !lat_reg.we;
  assign ret_valid = rd_done | err_rd;
  assign ret_data  = err_rd ? ERR_DATA : mem_rdata;

  // Per-requester return registers; data holds until that requester's next read.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    localparam logic OWN = 1'(gi);

    // Load this port's data and pulse its rvalid only for its own transactions.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid_reg[gi] <= 1'b0;
        rdata_reg[gi]  <= '0;
      end else begin
        rvalid_reg[gi] <= ret_valid && (owner_reg == req_id_t'(OWN));
        if (ret_valid && (owner_reg == req_id_t'(OWN))) begin
          rdata_reg[gi] <= ret_data;
        end
      end
    end
  end

  assign pci_rvalid = rvalid_reg[REQ_PCI];
  assign pci_rdata  = rdata_reg[REQ_PCI];
  assign usr_rvalid = rvalid_reg[REQ_USR];
  assign usr_rdata  = rdata_reg[REQ_USR];

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter. Instance A: RD_LAT=1, MEM_DEPTH=0F_FFFF,
// used for arbitration, write/read, out-of-range, reset and address-hold cases.
// Instance B: RD_LAT=3, default depth, used for the long-latency user read.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;

  // Instance A signals
  logic        pci_req, pci_we, usr_req, usr_we;
  logic [20:0] pci_addr, usr_addr;
  logic [31:0] pci_wdata, usr_wdata;
  logic        pci_gnt, pci_rvalid, usr_gnt, usr_rvalid;
  logic [31:0] pci_rdata, usr_rdata;
  logic        mem_en, mem_we, addr_err, busy;
  logic [20:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  // Instance B signals
  logic        b_usr_req;
  logic [20:0] b_usr_addr;
  logic        b_pci_gnt, b_pci_rvalid, b_usr_gnt, b_usr_rvalid;
  logic [31:0] b_pci_rdata, b_usr_rdata;
  logic        b_mem_en, b_mem_we, b_addr_err, b_busy;
  logic [20:0] b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  always #5 clk = ~clk;

  sram_port_arbiter #(.RD_LAT(1), .MEM_DEPTH(21'h0F_FFFF)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .pci_req(pci_req), .pci_we(pci_we), .pci_addr(pci_addr), .pci_wdata(pci_wdata),
    .pci_gnt(pci_gnt), .pci_rvalid(pci_rvalid), .pci_rdata(pci_rdata),
    .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
    .usr_gnt(usr_gnt), .usr_rvalid(usr_rvalid), .usr_rdata(usr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .addr_err(addr_err), .busy(busy)
  );

  sram_port_arbiter #(.RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .pci_req(1'b0), .pci_we(1'b0), .pci_addr(21'h0), .pci_wdata(32'h0),
    .pci_gnt(b_pci_gnt), .pci_rvalid(b_pci_rvalid), .pci_rdata(b_pci_rdata),
    .usr_req(b_usr_req), .usr_we(1'b0), .usr_addr(b_usr_addr), .usr_wdata(32'h0),
    .usr_gnt(b_usr_gnt), .usr_rvalid(b_usr_rvalid), .usr_rdata(b_usr_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .addr_err(b_addr_err), .busy(b_busy)
  );

  // Unwritten locations read back as their own address.
  function automatic logic [31:0] pat(input logic [20:0] a);
    return {11'h0, a};
  endfunction

  // SRAM model A: 1-cycle read latency, small tagged store for written words.
  logic [31:0]  mem_data [256];
  logic [20:0]  mem_tag  [256];
  logic [255:0] mem_vld = '0;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_data[mem_addr[7:0]] <= mem_wdata;
      mem_tag[mem_addr[7:0]]  <= mem_addr;
      mem_vld[mem_addr[7:0]]  <= 1'b1;
    end
    if (mem_en && !mem_we)
      mem_rdata <= (mem_vld[mem_addr[7:0]] && mem_tag[mem_addr[7:0]] == mem_addr)
                   ? mem_data[mem_addr[7:0]] : pat(mem_addr);
    else
      mem_rdata <= 32'h0BAD_0BAD;
  end

  // SRAM model B: 3-cycle read latency, fixed contents.
  function automatic logic [31:0] b_read(input logic [20:0] a);
    return (a == 21'h7FFFE) ? 32'h0001_0000 : pat(a);
  endfunction

  logic [31:0] b_pipe1, b_pipe2;
  always @(posedge clk) begin
    b_pipe1     <= (b_mem_en && !b_mem_we) ? b_read(b_mem_addr) : 32'h0BAD_0BAD;
    b_pipe2     <= b_pipe1;
    b_mem_rdata <= b_pipe2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [20:0] exp_addr;

    rst_n = 1'b0;
    pci_req = 1'b0; pci_we = 1'b0; pci_addr = '0; pci_wdata = '0;
    usr_req = 1'b0; usr_we = 1'b0; usr_addr = '0; usr_wdata = '0;
    b_usr_req = 1'b0; b_usr_addr = '0;

    // Both requesting reads from reset
    pci_req = 1'b1; pci_addr = 21'h100;
    usr_req = 1'b1; usr_addr = 21'h200;
    repeat (2) step();

    // Reset state
    check("rst_busy",      {31'h0, busy},     32'h0);
    check("rst_gnt",       {30'h0, pci_gnt, usr_gnt}, 32'h0);
    check("rst_mem_en",    {31'h0, mem_en},   32'h0);
    check("rst_addr_err",  {31'h0, addr_err}, 32'h0);
    check("rst_pci_rdata", pci_rdata,         32'h0);
    check("rst_usr_rdata", usr_rdata,         32'h0);
    check("rst_b_busy",    {31'h0, b_busy},   32'h0);
    rst_n = 1'b1;
    $display("reset released");

    // Round-robin over 8 back-to-back reads, PCI first
    for (int k = 0; k < 8; k++) begin
      exp_addr = (k % 2 == 0) ? 21'h100 : 21'h200;
      step();
      check("rr_gnt", {30'h0, pci_gnt, usr_gnt}, (k % 2 == 0) ? 32'h2 : 32'h1);
      check("rr_mem_addr", {11'h0, mem_addr}, {11'h0, exp_addr});
      if (k == 7) begin pci_req = 1'b0; usr_req = 1'b0; end
      step();
      check("rr_gnt_quiet", {30'h0, pci_gnt, usr_gnt}, 32'h0);
      step();
      check("rr_rvalid", {30'h0, pci_rvalid, usr_rvalid}, (k % 2 == 0) ? 32'h2 : 32'h1);
      check("rr_rdata", (k % 2 == 0) ? pci_rdata : usr_rdata, pat(exp_addr));
      $display("rr read %0d addr %h pci_gnt-first=%0d", k, exp_addr, (k % 2 == 0));
    end
    step();
    check("rr_idle_busy", {31'h0, busy}, 32'h0);

    // PCI write then read back @0x10
    pci_req = 1'b1; pci_we = 1'b1; pci_addr = 21'h10; pci_wdata = 32'h0000_1234;
    step();
    check("wr_gnt",   {30'h0, pci_gnt, usr_gnt}, 32'h2);
    check("wr_mem",   {30'h0, mem_en, mem_we},   32'h3);
    check("wr_addr",  {11'h0, mem_addr},         32'h10);
    check("wr_wdata", mem_wdata,                 32'h0000_1234);
    pci_req = 1'b0;
    step();
    check("wr_idle", {31'h0, busy}, 32'h0);
    pci_req = 1'b1; pci_we = 1'b0;
    step();
    check("rd_gnt", {30'h0, pci_gnt, mem_we}, 32'h2);
    pci_req = 1'b0;
    step();
    check("rd_wait_rvalid", {31'h0, pci_rvalid}, 32'h0);
    step();
    check("rd_rvalid", {31'h0, pci_rvalid}, 32'h1);
    check("rd_rdata",  pci_rdata, 32'h0000_1234);
    step();
    check("rd_rvalid_pulse", {31'h0, pci_rvalid}, 32'h0);
    check("rd_rdata_hold",   pci_rdata, 32'h0000_1234);
    $display("pci write/read 0x10 done");

    // Out-of-range read, then out-of-range write
    pci_req = 1'b1; pci_we = 1'b0; pci_addr = 21'h1F_FFFF;
    step();
    check("oor_gnt_err", {29'h0, pci_gnt, addr_err, mem_en}, 32'h6);
    pci_req = 1'b0;
    step();
    check("oor_rvalid", {30'h0, pci_rvalid, addr_err}, 32'h2);
    check("oor_rdata",  pci_rdata, 32'hDEAD_BEEF);
    check("oor_busy",   {31'h0, busy}, 32'h0);
    pci_req = 1'b1; pci_we = 1'b1; pci_wdata = 32'h55;
    step();
    check("oorw_gnt_err", {28'h0, pci_gnt, addr_err, mem_en, mem_we}, 32'hC);
    pci_req = 1'b0;
    step();
    check("oorw_no_rvalid", {31'h0, pci_rvalid}, 32'h0);
    check("oorw_rdata_hold", pci_rdata, 32'hDEAD_BEEF);
    $display("out-of-range read/write done");

    // USR changes address during RWAIT
    usr_req = 1'b1; usr_we = 1'b0; usr_addr = 21'h300;
    step();
    check("hold_gnt",  {30'h0, pci_gnt, usr_gnt}, 32'h1);
    check("hold_addr", {11'h0, mem_addr}, 32'h300);
    step();
    usr_addr = 21'h304;
    check("hold_wait_en", {31'h0, mem_en}, 32'h0);
    step();
    check("hold_rvalid", {31'h0, usr_rvalid}, 32'h1);
    check("hold_rdata",  usr_rdata, pat(21'h300));
    step();
    check("hold_regnt",  {30'h0, pci_gnt, usr_gnt}, 32'h1);
    check("hold_readdr", {11'h0, mem_addr}, 32'h304);
    usr_req = 1'b0;
    repeat (2) step();
    check("hold_rdata2", usr_rdata, pat(21'h304));
    $display("usr address change during RWAIT done");

    // Long-latency user read on instance B
    b_usr_req = 1'b1; b_usr_addr = 21'h7FFFE;
    step();
    check("lat3_gnt",  {30'h0, b_pci_gnt, b_usr_gnt}, 32'h1);
    check("lat3_addr", {11'h0, b_mem_addr}, 32'h7FFFE);
    check("lat3_wdata", b_mem_wdata, 32'h0);
    b_usr_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("lat3_early_rvalid", {30'h0, b_pci_rvalid, b_usr_rvalid}, 32'h0);
    end
    step();
    check("lat3_rvalid",    {30'h0, b_pci_rvalid, b_usr_rvalid}, 32'h1);
    check("lat3_rdata",     b_usr_rdata, 32'h0001_0000);
    check("lat3_pci_rdata", b_pci_rdata, 32'h0);
    check("lat3_addr_err",  {31'h0, b_addr_err}, 32'h0);
    $display("usr read 0x7FFFE RD_LAT=3 done");

    // Reset during RWAIT of a USR read
    usr_req = 1'b1; usr_addr = 21'h400;
    step();
    check("mrst_gnt", {31'h0, usr_gnt}, 32'h1);
    usr_req = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("mrst_busy",   {31'h0, busy},   32'h0);
    check("mrst_mem_en", {31'h0, mem_en}, 32'h0);
    check("mrst_rdata",  usr_rdata,       32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("mrst_no_rvalid", {30'h0, pci_rvalid, usr_rvalid}, 32'h0);
    end
    rst_n = 1'b1;
    pci_req = 1'b1; pci_we = 1'b0; pci_addr = 21'h10;
    step();
    check("mrst_pci_gnt", {30'h0, pci_gnt, usr_gnt}, 32'h2);
    pci_req = 1'b0;
    repeat (2) step();
    check("mrst_pci_rvalid", {30'h0, pci_rvalid, usr_rvalid}, 32'h2);
    check("mrst_pci_rdata",  pci_rdata, 32'h0000_1234);
    $display("reset during RWAIT then pci read done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
